hazard_scoreboard: RTL and testbench

- Parametrised RAW/control hazard unit for the decode stage.
- Tracks in-flight destination registers through a DEPTH-stage shift scoreboard and flags source conflicts.
- Optional forwarding mode: stalls only on load-use; otherwise emits one-hot bypass selects.
- Runs a programmable control-flush window and presents the writeback destination/enable at the scoreboard tail.

---
 rtl/hazard_scoreboard.sv | 133 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/control hazard unit.
// A DEPTH-entry shift scoreboard tracks in-flight destination registers; decode
// sources are compared against stages 1..DEPTH-1 to raise stall or bypass selects,
// a small counter holds wipe for a programmable window after a redirect, and the
// tail entry drives the register-file write port.
module hazard_scoreboard #(
  parameter int unsigned REG_BITS     = 3,
  parameter int unsigned DEPTH        = 3,
  parameter bit          FWD_EN       = 1'b0,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter bit          ZERO_REG_EN  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] rs,
  input  logic [REG_BITS-1:0] rt,
  input  logic [REG_BITS-1:0] rd,
  input  logic                use_rs,
  input  logic                use_rt,
  input  logic                use_rd,
  input  logic                wr_en,
  input  logic                is_load,
  input  logic                ctrl_hazard,
  output logic                stall,
  output logic                wipe,
  output logic [DEPTH-2:0]    fwd_rs,
  output logic [DEPTH-2:0]    fwd_rt,
  output logic [DEPTH-2:0]    fwd_rd,
  output logic [REG_BITS-1:0] wb_rd,
  output logic                wb_en
);

  // Index k of the packed arrays holds scoreboard stage k+1.
  logic [DEPTH-1:0][REG_BITS-1:0] sb_rd_q, sb_rd_d;
  logic [DEPTH-1:0]               sb_vld_q, sb_vld_d;
  // Only a load sitting in stage 1 can cause a stall; older loads are bypassable.
  logic                           ld1_q, ld1_d;
  logic [2:0]                     cnt_q, cnt_d;

  logic [2:0][REG_BITS-1:0] src;
  logic [2:0]               use_v;
  logic [2:0][DEPTH-2:0]    match;
  logic [2:0][DEPTH-2:0]    youngest;
  logic [2:0][DEPTH-2:0]    sel;
  logic [2:0]               hazard;
  logic                     ins;

  // Source 0 = rs, 1 = rt, 2 = rd (store data).
  assign src   = {rd, rt, rs};
  assign use_v = {use_rd, use_rt, use_rs};

  // Flush window: live on the redirect cycle and while the counter is nonzero.
  assign wipe = ctrl_hazard | (cnt_q != 3'd0);

  // Per-source match against stages 1..DEPTH-1 and hazard/bypass decision.
  always_comb begin
    match    = '0;
    youngest = '0;
    sel      = '0;
    hazard   = '0;
    for (int s = 0; s < 3; s++) begin
      logic found;
      found = 1'b0;
      for (int k = 0; k < int'(DEPTH) - 1; k++) begin
        match[s][k] = sb_vld_q[k] && (sb_rd_q[k] == src[s]) &&
                      !(ZERO_REG_EN && (src[s] == '0));
      end
      // Youngest producer wins when several stages hold the same register.
      for (int k = 0; k < int'(DEPTH) - 1; k++) begin
        if (match[s][k] && !found) begin
          youngest[s][k] = 1'b1;
          found          = 1'b1;
        end
      end
      if (FWD_EN) begin
        hazard[s] = use_v[s] & match[s][0] & ld1_q;
        sel[s]    = (use_v[s] && !(match[s][0] && ld1_q)) ? youngest[s] : '0;
      end else begin
        hazard[s] = use_v[s] & (|match[s]);
        sel[s]    = '0;
      end
    end
  end

  // A redirect squashes decode, so it takes priority over a stall.
  assign stall  = (|hazard) & ~wipe;
  assign fwd_rs = (stall || wipe) ? '0 : sel[0];
  assign fwd_rt = (stall || wipe) ? '0 : sel[1];
  assign fwd_rd = (stall || wipe) ? '0 : sel[2];

  // Stalled, wiped and zero-register writes enter the scoreboard as bubbles.
  assign ins = wr_en & ~stall & ~wipe & ~(ZERO_REG_EN & (rd == '0));

  // Scoreboard shift and flush-counter next state.
  always_comb begin
    sb_rd_d     = sb_rd_q;
    sb_vld_d    = sb_vld_q;
    sb_rd_d[0]  = rd;
    sb_vld_d[0] = ins;
    for (int k = 1; k < int'(DEPTH); k++) begin
      sb_rd_d[k]  = sb_rd_q[k-1];
      sb_vld_d[k] = sb_vld_q[k-1];
    end
    ld1_d = is_load & ins;

    if (ctrl_hazard) begin
      cnt_d = 3'(FLUSH_CYCLES - 1);
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset clears all pending entries and the flush window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_rd_q  <= '0;
      sb_vld_q <= '0;
      ld1_q    <= 1'b0;
      cnt_q    <= 3'd0;
    end else begin
      sb_rd_q  <= sb_rd_d;
      sb_vld_q <= sb_vld_d;
      ld1_q    <= ld1_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wb_rd = sb_rd_q[DEPTH-1];
  assign wb_en = sb_vld_q[DEPTH-1];

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: two instances (stall-only without
// zero register, and forwarding with hardwired r0) share one stimulus stream and
// are compared every cycle against an age-indexed reference model.
module tb_hazard_scoreboard;

  localparam int unsigned RB = 3;
  localparam int unsigned D  = 3;
  localparam int unsigned FC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [RB-1:0] rs, rt, rd;
  logic          use_rs, use_rt, use_rd, wr_en, is_load, ctrl_hazard;

  logic [1:0]           d_stall, d_wipe, d_wb_en;
  logic [1:0][D-2:0]    d_fwd_rs, d_fwd_rt, d_fwd_rd;
  logic [1:0][RB-1:0]   d_wb_rd;

  hazard_scoreboard #(
    .REG_BITS(RB), .DEPTH(D), .FWD_EN(1'b0), .FLUSH_CYCLES(FC), .ZERO_REG_EN(1'b0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd),
    .use_rs(use_rs), .use_rt(use_rt), .use_rd(use_rd),
    .wr_en(wr_en), .is_load(is_load), .ctrl_hazard(ctrl_hazard),
    .stall(d_stall[0]), .wipe(d_wipe[0]),
    .fwd_rs(d_fwd_rs[0]), .fwd_rt(d_fwd_rt[0]), .fwd_rd(d_fwd_rd[0]),
    .wb_rd(d_wb_rd[0]), .wb_en(d_wb_en[0])
  );

  hazard_scoreboard #(
    .REG_BITS(RB), .DEPTH(D), .FWD_EN(1'b1), .FLUSH_CYCLES(FC), .ZERO_REG_EN(1'b1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd),
    .use_rs(use_rs), .use_rt(use_rt), .use_rd(use_rd),
    .wr_en(wr_en), .is_load(is_load), .ctrl_hazard(ctrl_hazard),
    .stall(d_stall[1]), .wipe(d_wipe[1]),
    .fwd_rs(d_fwd_rs[1]), .fwd_rt(d_fwd_rt[1]), .fwd_rd(d_fwd_rd[1]),
    .wb_rd(d_wb_rd[1]), .wb_en(d_wb_en[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: m_*[i][age] = instruction issued 'age' cycles ago.
  int mdl_fwd[2] = '{0, 1};
  int mdl_zr[2]  = '{0, 1};
  int m_rd[2][D+1];
  bit m_v[2][D+1];
  bit m_ld[2][D+1];
  int cyc      = 0;
  int wipe_end = -1;

  // DUT outputs sampled at mid-cycle by the most recent drive_check.
  logic [1:0]         s_stall, s_wipe, s_wb_en;
  logic [1:0][D-2:0]  s_fwd_rs, s_fwd_rt, s_fwd_rd;
  logic [1:0][RB-1:0] s_wb_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k <= int'(D); k++) begin
        m_rd[i][k] = 0;
        m_v[i][k]  = 1'b0;
        m_ld[i][k] = 1'b0;
      end
    end
    wipe_end = -1;
  endtask

  // Hazard/bypass for one source from the in-flight list: find the youngest
  // in-flight writer of x younger than DEPTH cycles.
  task automatic model_src(input int i, input int x, input bit use_x,
                           output bit haz, output logic [D-2:0] sel);
    int young;
    young = 0;
    haz   = 1'b0;
    sel   = '0;
    if (use_x && !(mdl_zr[i] != 0 && x == 0)) begin
      for (int age = 1; age <= int'(D) - 1; age++) begin
        if (young == 0 && m_v[i][age] && m_rd[i][age] == x) young = age;
      end
      if (young != 0) begin
        if (mdl_fwd[i] == 0) haz = 1'b1;
        else if (young == 1 && m_ld[i][1]) haz = 1'b1;
        else sel[young-1] = 1'b1;
      end
    end
  endtask

  // Apply inputs, compare both DUTs to the model at mid-cycle, then advance the
  // model to the state it must hold after the next rising edge.
  task automatic drive_check(input bit r, input bit c, input int a, input int b, input int dd,
                             input bit ua, input bit ub, input bit ud,
                             input bit we, input bit ld);
    bit               e_wipe, e_stall, h0, h1, h2, ins;
    logic [D-2:0]     f0, f1, f2;
    bit               st[2];
    rst = r; ctrl_hazard = c;
    rs = RB'(a); rt = RB'(b); rd = RB'(dd);
    use_rs = ua; use_rt = ub; use_rd = ud; wr_en = we; is_load = ld;
    #4;
    if (r) model_clear();
    e_wipe = c || (cyc <= wipe_end);
    s_stall = d_stall; s_wipe = d_wipe; s_wb_en = d_wb_en; s_wb_rd = d_wb_rd;
    s_fwd_rs = d_fwd_rs; s_fwd_rt = d_fwd_rt; s_fwd_rd = d_fwd_rd;
    for (int i = 0; i < 2; i++) begin
      model_src(i, a, ua, h0, f0);
      model_src(i, b, ub, h1, f1);
      model_src(i, dd, ud, h2, f2);
      e_stall = (h0 || h1 || h2) && !e_wipe;
      if (e_stall || e_wipe) begin
        f0 = '0; f1 = '0; f2 = '0;
      end
      st[i] = e_stall;
      chk($sformatf("cyc%0d dut%0d stall", cyc, i), 32'(d_stall[i]), 32'(e_stall));
      chk($sformatf("cyc%0d dut%0d wipe", cyc, i), 32'(d_wipe[i]), 32'(e_wipe));
      chk($sformatf("cyc%0d dut%0d fwd_rs", cyc, i), 32'(d_fwd_rs[i]), 32'(f0));
      chk($sformatf("cyc%0d dut%0d fwd_rt", cyc, i), 32'(d_fwd_rt[i]), 32'(f1));
      chk($sformatf("cyc%0d dut%0d fwd_rd", cyc, i), 32'(d_fwd_rd[i]), 32'(f2));
      chk($sformatf("cyc%0d dut%0d wb_en", cyc, i), 32'(d_wb_en[i]), 32'(m_v[i][D]));
      chk($sformatf("cyc%0d dut%0d wb_rd", cyc, i), 32'(d_wb_rd[i]), 32'(m_rd[i][D]));
    end
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = int'(D); k >= 2; k--) begin
          m_rd[i][k] = m_rd[i][k-1];
          m_v[i][k]  = m_v[i][k-1];
          m_ld[i][k] = m_ld[i][k-1];
        end
        ins = we && !st[i] && !e_wipe && !(mdl_zr[i] != 0 && dd == 0);
        m_rd[i][1] = dd;
        m_v[i][1]  = ins;
        m_ld[i][1] = ins && ld;
      end
      if (c) wipe_end = cyc + int'(FC) - 1;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit r, input bit c, input int a, input int b, input int dd,
                      input bit ua, input bit ub, input bit ud, input bit we, input bit ld);
    drive_check(r, c, a, b, dd, ua, ub, ud, we, ld);
    tick();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ctrl_hazard = 1'b0; rs = '0; rt = '0; rd = '0;
    use_rs = 1'b0; use_rt = 1'b0; use_rd = 1'b0; wr_en = 1'b0; is_load = 1'b0;
    model_clear();
    tick();

    // Reset state; wipe follows ctrl_hazard while reset is held.
    step(1, 0, 3, 3, 3, 1, 1, 1, 1, 0);
    chk("rst stall0", 32'(s_stall[0]), 0);
    chk("rst wb_en0", 32'(s_wb_en[0]), 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst wipe=ctrl", 32'(s_wipe[0]), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post-rst wipe", 32'(s_wipe[1]), 0);

    // Write r3 then read it: stall two cycles without bypass, bypass 01 then 10.
    step(0, 0, 0, 0, 3, 0, 0, 0, 1, 0);
    step(0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    chk("raw stall c1", 32'(s_stall[0]), 1);
    chk("raw fwd c1", 32'(s_fwd_rs[1]), 32'b01);
    step(0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    chk("raw stall c2", 32'(s_stall[0]), 1);
    chk("raw fwd c2", 32'(s_fwd_rs[1]), 32'b10);
    step(0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    chk("raw stall c3", 32'(s_stall[0]), 0);
    chk("raw wb_en", 32'(s_wb_en[0]), 1);
    chk("raw wb_rd", 32'(s_wb_rd[0]), 3);
    idle(3);

    // ALU producer, immediate and one-apart consumers, then load-use.
    step(0, 0, 0, 0, 5, 0, 0, 0, 1, 0);
    step(0, 0, 0, 5, 0, 0, 1, 0, 0, 0);
    chk("alu fwd_rt 01", 32'(s_fwd_rt[1]), 32'b01);
    chk("alu no stall", 32'(s_stall[1]), 0);
    idle(3);
    step(0, 0, 0, 0, 5, 0, 0, 0, 1, 0);
    idle(1);
    step(0, 0, 0, 5, 0, 0, 1, 0, 0, 0);
    chk("alu fwd_rt 10", 32'(s_fwd_rt[1]), 32'b10);
    idle(3);
    step(0, 0, 0, 0, 5, 0, 0, 0, 1, 1);
    step(0, 0, 0, 5, 0, 0, 1, 0, 0, 0);
    chk("ld-use stall", 32'(s_stall[1]), 1);
    chk("ld-use fwd off", 32'(s_fwd_rt[1]), 0);
    step(0, 0, 0, 5, 0, 0, 1, 0, 0, 0);
    chk("ld-use release", 32'(s_stall[1]), 0);
    chk("ld-use fwd 10", 32'(s_fwd_rt[1]), 32'b10);
    idle(3);

    // Two back-to-back writers of r2: the younger one is selected.
    step(0, 0, 0, 0, 2, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 2, 0, 0, 0, 1, 0);
    step(0, 0, 2, 0, 0, 1, 0, 0, 0, 0);
    chk("youngest fwd_rs", 32'(s_fwd_rs[1]), 32'b01);
    idle(3);

    // Single redirect: three wiped cycles whose writes never reach writeback.
    step(0, 1, 0, 0, 4, 0, 0, 0, 1, 0);
    chk("flush w0", 32'(s_wipe[0]), 1);
    step(0, 0, 0, 0, 4, 0, 0, 0, 1, 0);
    chk("flush w1", 32'(s_wipe[0]), 1);
    step(0, 0, 0, 0, 4, 0, 0, 0, 1, 0);
    chk("flush w2", 32'(s_wipe[1]), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush w3 off", 32'(s_wipe[0]), 0);
    chk("flush wb0", 32'(s_wb_en[0]), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush wb1", 32'(s_wb_en[1]), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush wb2", 32'(s_wb_en[0]), 0);
    // Second pulse on window cycle 2 stretches the window to four cycles.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reload w3", 32'(s_wipe[0]), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reload w4 off", 32'(s_wipe[0]), 0);
    idle(1);

    // r0 is ignored only by the zero-register instance.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("r0 stall zr", 32'(s_stall[1]), 0);
    chk("r0 fwd zr", 32'(s_fwd_rs[1]), 0);
    chk("r0 stall nozr", 32'(s_stall[0]), 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0 wb zr", 32'(s_wb_en[1]), 0);
    chk("r0 wb nozr", 32'(s_wb_en[0]), 1);
    idle(2);

    // Asynchronous reset while stalled with a live writeback.
    step(0, 0, 0, 0, 6, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 3, 0, 0, 0, 1, 0);
    step(0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    drive_check(0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    chk("pre-arst stall", 32'(s_stall[0]), 1);
    chk("pre-arst wb_en", 32'(s_wb_en[0]), 1);
    chk("pre-arst wb_rd", 32'(s_wb_rd[0]), 6);
    #1 rst = 1'b1;
    #1;
    chk("arst stall", 32'(d_stall[0]), 0);
    chk("arst wb_en", 32'(d_wb_en[0]), 0);
    chk("arst wb_rd", 32'(d_wb_rd[0]), 0);
    model_clear();
    tick();
    step(1, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    chk("post-arst no stall", 32'(s_stall[0]), 0);
    idle(2);

    // Asynchronous reset in the middle of a flush window.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_check(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre-arst wipe", 32'(s_wipe[0]), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst wipe0", 32'(d_wipe[0]), 0);
    chk("arst wipe1", 32'(d_wipe[1]), 0);
    model_clear();
    tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post-arst wipe", 32'(s_wipe[0]), 0);

    // Randomized traffic with occasional redirects and resets.
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 15) == 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
